// File: rtl/rx_frame_sr_if.sv
// rx_frame_sr_if: serial-bit input and completed-frame status bundle
// for the parametrised UART receive-frame shift register.
interface rx_frame_sr_if #(
   parameter int MAX_DATA_BITS = 8,
   parameter int SZW           = $clog2(MAX_DATA_BITS + 1)
);
   logic                     shift_strobe;
   logic                     serial_in;
   logic [SZW-1:0]           data_size;
   logic [1:0]               parity_mode;
   logic                     frame_clear;
   logic [MAX_DATA_BITS-1:0] packet_data;
   logic                     parity_bit;
   logic                     stop_bit;
   logic                     parity_error;
   logic                     framing_error;
   logic                     frame_valid;
   logic [SZW:0]             bit_count;

   modport master (
      output shift_strobe,
      output serial_in,
      output data_size,
      output parity_mode,
      output frame_clear,
      input  packet_data,
      input  parity_bit,
      input  stop_bit,
      input  parity_error,
      input  framing_error,
      input  frame_valid,
      input  bit_count
   );

   modport slave (
      input  shift_strobe,
      input  serial_in,
      input  data_size,
      input  parity_mode,
      input  frame_clear,
      output packet_data,
      output parity_bit,
      output stop_bit,
      output parity_error,
      output framing_error,
      output frame_valid,
      output bit_count
   );
endinterface

// File: rtl/rx_frame_sr.sv
// rx_frame_sr: LSB-first UART receive-frame assembler, 5..MAX_DATA_BITS data.
// Define RX_SR_PARITY_EN to build the parity checker and mode register.
module rx_frame_sr #(
   parameter int MAX_DATA_BITS = 8,
   parameter int SZW           = $clog2(MAX_DATA_BITS + 1)
) (
   input logic          clk,
   input logic          rst,
   rx_frame_sr_if.slave rx
);
   localparam int W  = MAX_DATA_BITS + 2;
   localparam int CW = SZW + 1;
   localparam logic [SZW-1:0] MAX_SZ = SZW'(MAX_DATA_BITS);
   localparam logic [SZW-1:0] MIN_SZ = SZW'(5);

   logic [W-1:0]             sr_q, sr_d;
   logic [W-1:0]             sr_shift, frame;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [CW-1:0]            len, stop_pos;
   logic [SZW-1:0]           size_q, size_d;
   logic [SZW-1:0]           size_in, size_cur;
   logic [MAX_DATA_BITS-1:0] pkt_q, pkt_d;
   logic [MAX_DATA_BITS-1:0] mask, data;
   logic                     stop_q, stop_d;
   logic                     ferr_q, ferr_d;
   logic                     valid_q, valid_d;
   logic                     start, last, stop_rx;
   logic                     p_cur, odd_cur;
   logic                     unused;

   assign start   = (cnt_q == '0);
   assign size_in = (rx.data_size < MIN_SZ || rx.data_size > MAX_SZ)
                  ? MAX_SZ : rx.data_size;
   assign size_cur = start ? size_in : size_q;

   assign len      = CW'(size_cur) + CW'(p_cur) + CW'(1);
   assign stop_pos = CW'(size_cur) + CW'(p_cur);
   assign last     = rx.shift_strobe && !rx.frame_clear
                  && (cnt_q == len - CW'(1));

   // Frame sits in the top len bits after the final shift; right-justify it.
   assign sr_shift = {rx.serial_in, sr_q[W-1:1]};
   assign frame    = sr_shift >> (CW'(W) - len);

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_DATA_BITS; i++)
         mask[i] = (SZW'(i) < size_cur);
   end

   assign data = frame[MAX_DATA_BITS-1:0] & mask;

   always_comb begin
      stop_rx = 1'b1;
      for (int i = 0; i < W; i++)
         if (CW'(i) == stop_pos) stop_rx = frame[i];
   end

   always_comb begin
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      size_d  = size_q;
      pkt_d   = pkt_q;
      stop_d  = stop_q;
      ferr_d  = ferr_q;
      valid_d = 1'b0;
      if (rx.frame_clear) begin
         sr_d  = '1;
         cnt_d = '0;
      end else if (rx.shift_strobe) begin
         if (start) size_d = size_in;
         if (last) begin
            sr_d    = '1;
            cnt_d   = '0;
            pkt_d   = data;
            stop_d  = stop_rx;
            ferr_d  = ~stop_rx;
            valid_d = 1'b1;
         end else begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q    <= '1;
         cnt_q   <= '0;
         size_q  <= MAX_SZ;
         pkt_q   <= '1;
         stop_q  <= 1'b1;
         ferr_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         size_q  <= size_d;
         pkt_q   <= pkt_d;
         stop_q  <= stop_d;
         ferr_q  <= ferr_d;
         valid_q <= valid_d;
      end
   end

`ifdef RX_SR_PARITY_EN
   // mode_q = {odd, parity present}
   logic [1:0] mode_q, mode_d, mode_in, mode_cur;
   logic       pbit_q, pbit_d;
   logic       perr_q, perr_d;
   logic       par_rx;

   always_comb begin
      unique case (rx.parity_mode)
         2'b01:   mode_in = 2'b01;
         2'b10:   mode_in = 2'b11;
         default: mode_in = 2'b00;
      endcase
   end

   assign mode_cur = start ? mode_in : mode_q;
   assign p_cur    = mode_cur[0];
   assign odd_cur  = mode_cur[1];

   always_comb begin
      par_rx = 1'b1;
      for (int i = 0; i < W; i++)
         if (CW'(i) == CW'(size_cur)) par_rx = frame[i];
   end

   always_comb begin
      mode_d = mode_q;
      pbit_d = pbit_q;
      perr_d = perr_q;
      if (rx.shift_strobe && !rx.frame_clear && start)
         mode_d = mode_in;
      if (last) begin
         pbit_d = p_cur ? par_rx : 1'b1;
         perr_d = p_cur && (par_rx != ((^data) ^ odd_cur));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= 2'b00;
         pbit_q <= 1'b1;
         perr_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         pbit_q <= pbit_d;
         perr_q <= perr_d;
      end
   end

   assign rx.parity_bit   = pbit_q;
   assign rx.parity_error = perr_q;
   assign unused          = sr_q[0];
`else
   assign p_cur           = 1'b0;
   assign odd_cur         = 1'b0;
   assign rx.parity_bit   = 1'b1;
   assign rx.parity_error = 1'b0;
   assign unused          = ^{sr_q[0], odd_cur, rx.parity_mode};
`endif

   assign rx.packet_data   = pkt_q;
   assign rx.stop_bit      = stop_q;
   assign rx.framing_error = ferr_q;
   assign rx.frame_valid   = valid_q;
   assign rx.bit_count     = cnt_q;
endmodule

// File: tb/tb_rx_frame_sr.sv
// tb_rx_frame_sr: table vectors, corner sequences and random stimulus
// against a bit-queue reference model of the receive frame.
module tb_rx_frame_sr;
   localparam int MAXB = 8;
   localparam int SZW  = $clog2(MAXB + 1);
`ifdef RX_SR_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rx_frame_sr_if #(.MAX_DATA_BITS(MAXB)) rx();
   rx_frame_sr #(.MAX_DATA_BITS(MAXB)) dut (
      .clk(clk),
      .rst(rst),
      .rx (rx)
   );

   int total = 0;
   int bad   = 0;

   bit q[$];
   int m_size, m_p, m_odd;
   int m_pkt, m_pbit, m_stop, m_perr, m_ferr, m_valid;

   typedef struct {
      int          dsz;
      int          pm;
      int          n;
      logic [17:0] bits;
      logic [7:0]  pkt;
      bit          ferr;
   } vec_t;

   vec_t vt[7];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pkt = 255; m_pbit = 1; m_stop = 1;
      m_perr = 0; m_ferr = 0; m_valid = 0;
   endtask

   task automatic model_step(bit s, bit b, bit c, int dsz, int pm);
      int d, ones, par, expp;
      m_valid = 0;
      if (c) begin
         q.delete();
      end else if (s) begin
         if (q.size() == 0) begin
            m_size = (dsz < 5 || dsz > MAXB) ? MAXB : dsz;
            m_p    = (PAR && (pm == 1 || pm == 2)) ? 1 : 0;
            m_odd  = (PAR && pm == 2) ? 1 : 0;
         end
         q.push_back(b);
         if (q.size() == m_size + m_p + 1) begin
            d = 0; ones = 0;
            for (int i = 0; i < m_size; i++) begin
               d += int'(q[i]) * (1 << i);
               ones += int'(q[i]);
            end
            par    = m_p ? int'(q[m_size]) : 1;
            expp   = (ones % 2) ^ m_odd;
            m_pkt  = d;
            m_pbit = par;
            m_stop = int'(q[m_size + m_p]);
            m_ferr = 1 - m_stop;
            m_perr = (m_p == 1 && par != expp) ? 1 : 0;
            m_valid = 1;
            q.delete();
         end
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".pkt"},   32'(rx.packet_data),   32'(m_pkt));
      chk({tag, ".pbit"},  32'(rx.parity_bit),    32'(m_pbit));
      chk({tag, ".stop"},  32'(rx.stop_bit),      32'(m_stop));
      chk({tag, ".perr"},  32'(rx.parity_error),  32'(m_perr));
      chk({tag, ".ferr"},  32'(rx.framing_error), 32'(m_ferr));
      chk({tag, ".valid"}, 32'(rx.frame_valid),   32'(m_valid));
      chk({tag, ".cnt"},   32'(rx.bit_count),     32'(q.size()));
   endtask

   task automatic cycle(string tag, bit s, bit b, bit c, int dsz, int pm);
      rx.shift_strobe = s;
      rx.serial_in    = b;
      rx.frame_clear  = c;
      rx.data_size    = SZW'(dsz);
      rx.parity_mode  = 2'(pm);
      model_step(s, b, c, dsz, pm);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic send(string tag, int dsz, int pm, int n, logic [17:0] bits);
      for (int i = 0; i < n; i++)
         cycle(tag, 1'b1, bits[i], 1'b0, dsz, pm);
   endtask

   task automatic frame_chk(string tag, logic [7:0] pkt, bit ferr,
                            bit pbit, bit perr);
      chk({tag, ".v"},    32'(rx.frame_valid),   32'd1);
      chk({tag, ".data"}, 32'(rx.packet_data),   32'(pkt));
      chk({tag, ".fe"},   32'(rx.framing_error), 32'(ferr));
      chk({tag, ".pb"},   32'(rx.parity_bit),    32'(pbit));
      chk({tag, ".pe"},   32'(rx.parity_error),  32'(perr));
   endtask

   initial begin
      vt[0] = '{5,  0, 6, 18'h00033, 8'h13, 1'b0};
      vt[1] = '{5,  0, 6, 18'h00013, 8'h13, 1'b1};
      vt[2] = '{8,  0, 9, 18'h001A5, 8'hA5, 1'b0};
      vt[3] = '{6,  3, 7, 18'h0006A, 8'h2A, 1'b0};
      vt[4] = '{0,  0, 9, 18'h0013C, 8'h3C, 1'b0};
      vt[5] = '{12, 0, 9, 18'h000C3, 8'hC3, 1'b1};
      vt[6] = '{7,  0, 8, 18'h000FF, 8'h7F, 1'b0};

      rx.shift_strobe = 1'b0;
      rx.serial_in    = 1'b0;
      rx.frame_clear  = 1'b0;
      rx.data_size    = SZW'(8);
      rx.parity_mode  = 2'b00;
      model_reset();

      #7 rst = 1'b1;
      #1;
      chk("rst.pkt",  32'(rx.packet_data), 32'hFF);
      chk("rst.stop", 32'(rx.stop_bit),    32'd1);
      chk("rst.pe",   32'(rx.parity_error), 32'd0);
      chk("rst.v",    32'(rx.frame_valid), 32'd0);
      chk("rst.cnt",  32'(rx.bit_count),   32'd0);
      @(posedge clk);
      #1;
      check_all("rst_hold");
      rst = 1'b0;

      for (int k = 0; k < 7; k++) begin
         send("vec", vt[k].dsz, vt[k].pm, vt[k].n, vt[k].bits);
         frame_chk($sformatf("vec%0d", k), vt[k].pkt, vt[k].ferr, 1'b1, 1'b0);
         cycle("vec_idle", 1'b0, 1'b0, 1'b0, 8, 0);
         chk($sformatf("vec%0d.vlow", k), 32'(rx.frame_valid), 32'd0);
      end

      for (int pm = 1; pm <= 2; pm++) begin
         send("par", 8, pm, 9, 18'h0024D);
         if (PAR) begin
            chk("par.cnt9", 32'(rx.bit_count), 32'd9);
            cycle("par", 1'b1, 1'b1, 1'b0, 8, pm);
            frame_chk($sformatf("par%0d", pm), 8'h4D, 1'b0, 1'b0, pm == 2);
         end else begin
            frame_chk($sformatf("par%0d", pm), 8'h4D, 1'b1, 1'b1, 1'b0);
            cycle("par", 1'b1, 1'b1, 1'b0, 8, pm);
            chk("par.cnt1", 32'(rx.bit_count), 32'd1);
         end
         cycle("par_clr", 1'b0, 1'b0, 1'b1, 8, 0);
      end

      send("abort", 8, 0, 4, 18'h0000B);
      cycle("abort", 1'b1, 1'b1, 1'b1, 8, 0);
      chk("abort.cnt",  32'(rx.bit_count),   32'd0);
      chk("abort.v",    32'(rx.frame_valid), 32'd0);
      chk("abort.hold", 32'(rx.packet_data), 32'h4D);
      send("a5", 8, 0, 9, 18'h001A5);
      frame_chk("a5", 8'hA5, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 9; i++) begin
         cycle("szchg", 1'b1, 18'h0015A >> i, 1'b0, (i < 2) ? 8 : 6, 0);
         if (i == 6) chk("szchg.v7", 32'(rx.frame_valid), 32'd0);
         if (i == 7) chk("szchg.cnt8", 32'(rx.bit_count), 32'd8);
      end
      frame_chk("szchg", 8'h5A, 1'b0, 1'b1, 1'b0);

      send("rmid", 8, 0, 3, 18'h00005);
      #3 rst = 1'b1;
      model_reset();
      #1;
      check_all("rmid");
      chk("rmid.cnt", 32'(rx.bit_count), 32'd0);
      @(posedge clk);
      #1;
      check_all("rmid_hold");
      rst = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom),
               $urandom_range(0, 39) == 0, $urandom_range(0, 15),
               $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
